// File: rtl/traffic_phase_timer_if.sv
// rtl/traffic_phase_timer_if.sv - control and lamp signals between the phase timer and its neighbours
interface traffic_phase_timer_if #(
    parameter int NBITS = 8
);
    logic             enable;
    logic             ped_req;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             ped_walk;
    logic             ped_pending;
    logic [2:0]       phase;
    logic [NBITS-1:0] count;

    // Timer side: consumes enable/ped_req, drives lamps and status.
    modport master (
        input  enable,
        input  ped_req,
        output ns_light,
        output ew_light,
        output ped_walk,
        output ped_pending,
        output phase,
        output count
    );

    // Intersection / lamp-driver side.
    modport slave (
        output enable,
        output ped_req,
        input  ns_light,
        input  ew_light,
        input  ped_walk,
        input  ped_pending,
        input  phase,
        input  count
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - six-phase two-road signal timer with latched pedestrian walk
module traffic_phase_timer #(
    parameter int NBITS    = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int PED_T    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_phase_timer_if.master bus
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_e;

    // Terminal counts: a phase of duration d expires when count reaches d-1.
    localparam logic [NBITS-1:0] GREEN_M1  = NBITS'(GREEN_T - 1);
    localparam logic [NBITS-1:0] YELLOW_M1 = NBITS'(YELLOW_T - 1);
    localparam logic [NBITS-1:0] ALLRED_M1 = NBITS'(ALLRED_T - 1);
    localparam logic [NBITS-1:0] PED_M1    = NBITS'(PED_T - 1);

    // Kept as plain bits so the illegal encodings 6/7 remain representable.
    logic [2:0]       state_q, state_d;
    logic [NBITS-1:0] count_q, count_d;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_q, walk_d;
    logic             serve;

    logic [NBITS-1:0] dur_m1;
    logic [NBITS-1:0] count_inc;
    logic [NBITS-1:0] carry;
    logic [NBITS-1:0] bit_eq;
    logic             expire;

    // Incrementer: ripple of full adders with b=0 and carry-in 1; final carry-out dropped.
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < NBITS; i++) begin : g_fa
        assign count_inc[i] = count_q[i] ^ 1'b0 ^ carry[i];
        if (i < NBITS - 1) begin : g_cout
            assign carry[i+1] = (count_q[i] & 1'b0) | (carry[i] & (count_q[i] ^ 1'b0));
        end
    end

    // Equality comparator: per-bit XNOR reduced by AND.
    assign bit_eq = ~(count_q ^ dur_m1);
    assign expire = &bit_eq;

    // Terminal count for the phase currently held in the state register.
    always_comb begin
        dur_m1 = ALLRED_M1;
        case (state_q)
            NS_GREEN, EW_GREEN:   dur_m1 = GREEN_M1;
            NS_YELLOW, EW_YELLOW: dur_m1 = YELLOW_M1;
            default:              dur_m1 = walk_q ? PED_M1 : ALLRED_M1;
        endcase
    end

    // Next-state, counter and pedestrian bookkeeping.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        walk_d  = walk_q;
        serve   = 1'b0;
        if (state_q > 3'd5) begin
            // Illegal encoding recovers to a safe all-red regardless of enable.
            state_d = ALLRED_A;
            count_d = '0;
            walk_d  = 1'b0;
        end else if (bus.enable) begin
            if (expire) begin
                count_d = '0;
                state_d = (state_q == ALLRED_B) ? NS_GREEN : state_q + 3'd1;
                if ((state_q == NS_YELLOW || state_q == EW_YELLOW) && ped_pending_q) begin
                    serve  = 1'b1;
                    walk_d = 1'b1;
                end
                if (state_q == ALLRED_A || state_q == ALLRED_B) begin
                    walk_d = 1'b0;
                end
            end else begin
                count_d = count_inc;
            end
        end
        // A request coinciding with the serve edge stays pending for the next all-red.
        ped_pending_d = (ped_pending_q & ~serve) | bus.ped_req;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= NS_GREEN;
            count_q       <= '0;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    // Lamp decode from the state register only; lamps are {red,yellow,green}.
    always_comb begin
        bus.ns_light = 3'b100;
        bus.ew_light = 3'b100;
        case (state_q)
            NS_GREEN:  begin bus.ns_light = 3'b001; bus.ew_light = 3'b100; end
            NS_YELLOW: begin bus.ns_light = 3'b010; bus.ew_light = 3'b100; end
            EW_GREEN:  begin bus.ns_light = 3'b100; bus.ew_light = 3'b001; end
            EW_YELLOW: begin bus.ns_light = 3'b100; bus.ew_light = 3'b010; end
            default:   begin bus.ns_light = 3'b100; bus.ew_light = 3'b100; end
        endcase
    end

    assign bus.ped_walk    = walk_q;
    assign bus.ped_pending = ped_pending_q;
    assign bus.phase       = state_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - directed self-checking bench for traffic_phase_timer
module tb_traffic_phase_timer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [2:0] ph_tbl  [16];
    logic [3:0] cnt_tbl [16];

    traffic_phase_timer_if #(.NBITS(4)) bus ();

    traffic_phase_timer #(
        .NBITS(4),
        .GREEN_T(5),
        .YELLOW_T(2),
        .ALLRED_T(1),
        .PED_T(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        clk         = 1'b0;
        checks      = 0;
        failures    = 0;
        ph_tbl      = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                        3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};
        cnt_tbl     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd0,
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd0};
        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.ped_req = 1'b0;

        // Reset state
        step(1);
        rst_n = 1'b1;
        chk("rst_phase",   8'(bus.phase),       8'd0);
        chk("rst_count",   8'(bus.count),       8'd0);
        chk("rst_ns",      8'(bus.ns_light),    8'b001);
        chk("rst_ew",      8'(bus.ew_light),    8'b100);
        chk("rst_walk",    8'(bus.ped_walk),    8'd0);
        chk("rst_pending", 8'(bus.ped_pending), 8'd0);

        // Free-running cycle without pedestrians, two full periods of 16
        bus.enable = 1'b1;
        for (int c = 0; c < 32; c++) begin
            chk("cyc_phase", 8'(bus.phase), 8'(ph_tbl[c % 16]));
            chk("cyc_count", 8'(bus.count), 8'(cnt_tbl[c % 16]));
            if (c < 5) chk("cyc_ns_green", 8'(bus.ns_light), 8'b001);
            else if (c < 7) chk("cyc_ns_yellow", 8'(bus.ns_light), 8'b010);
            step(1);
        end

        // Single-cycle pedestrian pulse at NS_GREEN count=2
        step(2);
        chk("ped_at_cnt2", 8'(bus.count), 8'd2);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        chk("ped_latched", 8'(bus.ped_pending), 8'd1);
        step(4);
        chk("ped_ara_phase",   8'(bus.phase),       8'd2);
        chk("ped_ara_walk",    8'(bus.ped_walk),    8'd1);
        chk("ped_ara_pending", 8'(bus.ped_pending), 8'd0);
        step(2);
        chk("ped_ara_last",    8'(bus.phase),       8'd2);
        chk("ped_ara_lastcnt", 8'(bus.count),       8'd2);
        step(1);
        chk("ped_ewg_phase",   8'(bus.phase),       8'd3);
        chk("ped_ewg_walk",    8'(bus.ped_walk),    8'd0);
        step(7);
        chk("ped_arb_phase",   8'(bus.phase),       8'd5);
        chk("ped_arb_walk",    8'(bus.ped_walk),    8'd0);
        step(1);
        chk("ped_arb_short",   8'(bus.phase),       8'd0);

        // Request held high: both all-reds extended, pending re-latched
        bus.ped_req = 1'b1;
        step(7);
        chk("hold_ara_phase",   8'(bus.phase),       8'd2);
        chk("hold_ara_walk",    8'(bus.ped_walk),    8'd1);
        chk("hold_ara_pending", 8'(bus.ped_pending), 8'd1);
        step(2);
        chk("hold_ara_end",     8'(bus.phase),       8'd2);
        step(1);
        chk("hold_ewg",         8'(bus.phase),       8'd3);
        step(7);
        chk("hold_arb_phase",   8'(bus.phase),       8'd5);
        chk("hold_arb_walk",    8'(bus.ped_walk),    8'd1);
        chk("hold_arb_pending", 8'(bus.ped_pending), 8'd1);
        step(2);
        chk("hold_arb_end",     8'(bus.phase),       8'd5);
        step(1);
        chk("hold_nsg_phase",   8'(bus.phase),       8'd0);
        chk("hold_nsg_walk",    8'(bus.ped_walk),    8'd0);
        bus.ped_req = 1'b0;

        // Pending request served at ALLRED_A (3 cycles), then freeze at EW_GREEN count=3
        step(13);
        chk("frz_pre_phase", 8'(bus.phase), 8'd3);
        chk("frz_pre_count", 8'(bus.count), 8'd3);
        bus.enable = 1'b0;
        step(1);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        chk("frz_ped_latch", 8'(bus.ped_pending), 8'd1);
        step(2);
        chk("frz_phase", 8'(bus.phase), 8'd3);
        chk("frz_count", 8'(bus.count), 8'd3);
        bus.enable = 1'b1;
        step(1);
        chk("frz_resume_phase", 8'(bus.phase), 8'd3);
        chk("frz_resume_count", 8'(bus.count), 8'd4);
        step(1);
        chk("frz_ewy_phase", 8'(bus.phase),    8'd4);
        chk("frz_ewy_ew",    8'(bus.ew_light), 8'b010);
        chk("frz_ewy_ns",    8'(bus.ns_light), 8'b100);

        // Pending served at ALLRED_B, then re-request and reset at NS_YELLOW count=1
        step(2);
        chk("arb_walk_phase", 8'(bus.phase),    8'd5);
        chk("arb_walk",       8'(bus.ped_walk), 8'd1);
        step(3);
        chk("arb_walk_exit",  8'(bus.phase),    8'd0);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        step(5);
        chk("pre_rst_phase",   8'(bus.phase),       8'd1);
        chk("pre_rst_count",   8'(bus.count),       8'd1);
        chk("pre_rst_pending", 8'(bus.ped_pending), 8'd1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_phase",   8'(bus.phase),       8'd0);
        chk("mid_rst_count",   8'(bus.count),       8'd0);
        chk("mid_rst_pending", 8'(bus.ped_pending), 8'd0);
        chk("mid_rst_ns",      8'(bus.ns_light),    8'b001);

        // Illegal encoding recovers to ALLRED_A
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        step(1);
        chk("ill_phase", 8'(bus.phase),    8'd2);
        chk("ill_count", 8'(bus.count),    8'd0);
        chk("ill_ns",    8'(bus.ns_light), 8'b100);
        chk("ill_ew",    8'(bus.ew_light), 8'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
